// File: rtl/fifo_rd_fwft_if.sv
// fifo_rd_fwft_if: memory read port plus AXI-Stream master bundle for fifo_rd_fwft
interface fifo_rd_fwft_if #(
    parameter int DATA_WIDTH = 8,
    parameter int RD_LATENCY = 1
);
    localparam int CW = $clog2(RD_LATENCY + 2);
    logic                  i_empty;
    logic                  o_rd_en;
    logic [DATA_WIDTH-1:0] i_rd_data;
    logic [DATA_WIDTH-1:0] m_axis_tdata;
    logic                  m_axis_tvalid;
    logic                  m_axis_tready;
    logic [CW-1:0]         o_count;
    modport master (
        input  i_empty, i_rd_data, m_axis_tready,
        output o_rd_en, m_axis_tdata, m_axis_tvalid, o_count
    );
    modport slave (
        output i_empty, i_rd_data, m_axis_tready,
        input  o_rd_en, m_axis_tdata, m_axis_tvalid, o_count
    );
endinterface

// File: rtl/fifo_rd_fwft.sv
// fifo_rd_fwft: turns a fixed-latency FIFO read port into a first-word-fall-through AXI-Stream source
module fifo_rd_fwft #(
    parameter int DATA_WIDTH = 8,
    parameter int RD_LATENCY = 1
) (
    input logic            i_clk,
    input logic            i_reset,
    fifo_rd_fwft_if.master bus
);
    localparam int BUF_DEPTH = RD_LATENCY + 1;
    localparam int CW = $clog2(BUF_DEPTH + 1);
    localparam int OW = CW + 1;
    localparam int AW = $clog2(BUF_DEPTH);

    logic [RD_LATENCY-1:0] in_flight;
    logic [DATA_WIDTH-1:0] mem [BUF_DEPTH];
    logic [AW-1:0]         head, tail;
    logic [CW-1:0]         count, flight_cnt;
    logic [OW-1:0]         occupancy;
    logic                  capture, pop, rd_en;

    function automatic logic [AW-1:0] wrap_inc(input logic [AW-1:0] p);
        return (p == AW'(BUF_DEPTH - 1)) ? '0 : p + AW'(1);
    endfunction

    assign capture           = in_flight[RD_LATENCY-1];
    assign pop               = (count != '0) && bus.m_axis_tready;
    assign bus.m_axis_tvalid = count != '0;
    assign bus.m_axis_tdata  = mem[head];
    assign bus.o_count       = count;
    assign bus.o_rd_en       = rd_en;

    // Number of reads issued whose data has not been captured yet
    always_comb begin
        flight_cnt = '0;
        for (int i = 0; i < RD_LATENCY; i++) flight_cnt = flight_cnt + CW'(in_flight[i]);
    end

    // Issue a read only when its returning word is guaranteed a free slot
    always_comb begin
        occupancy = {1'b0, count} + {1'b0, flight_cnt} - OW'(pop);
        rd_en     = !i_reset && !bus.i_empty && (occupancy < OW'(BUF_DEPTH));
    end

    // In-flight markers, ring pointers and occupancy
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            in_flight <= '0;
            head      <= '0;
            tail      <= '0;
            count     <= '0;
        end else begin
            in_flight <= RD_LATENCY'({in_flight, rd_en});
            if (capture) tail <= wrap_inc(tail);
            if (pop) head <= wrap_inc(head);
            if (capture != pop) count <= capture ? count + CW'(1) : count - CW'(1);
        end
    end

    // Ring storage, cleared on reset so the stream data reads zero
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            for (int i = 0; i < BUF_DEPTH; i++) mem[i] <= '0;
        end else if (capture) begin
            mem[tail] <= bus.i_rd_data;
        end
    end
endmodule

// File: tb/tb_fifo_rd_fwft.sv
// tb_fifo_rd_fwft: vector table, corner sequences and scoreboarded stress for fifo_rd_fwft
module tb_fifo_rd_fwft;
    typedef struct {
        bit tr;
        bit rd;
        bit v;
        int d;
        int c;
    } vec_t;

    logic clk = 0;
    logic rst1, rst3;
    always #5 clk = ~clk;

    fifo_rd_fwft_if #(.DATA_WIDTH(8), .RD_LATENCY(1)) b1 ();
    fifo_rd_fwft_if #(.DATA_WIDTH(8), .RD_LATENCY(3)) b3 ();
    fifo_rd_fwft #(.DATA_WIDTH(8), .RD_LATENCY(1)) d1 (.i_clk(clk), .i_reset(rst1), .bus(b1));
    fifo_rd_fwft #(.DATA_WIDTH(8), .RD_LATENCY(3)) d3 (.i_clk(clk), .i_reset(rst3), .bus(b3));

    int total = 0, bad = 0;
    int rp1, lim1, rp3, lim3, npop1, npop3;
    bit fe1, fe3, tr1, tr3;
    logic [7:0] pp1;
    logic [7:0] pp3 [3];
    logic [7:0] q1 [$];
    logic [7:0] q3 [$];
    int s_rd1, s_v1, s_d1, s_c1, s_rd3, s_v3, s_d3, s_c3;
    vec_t tv [11];

    function automatic logic [7:0] w(input int k);
        return 8'(k + 1);
    endfunction

    task automatic chk(input string n, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", n, act, exp);
        end
    endtask

    task automatic drive();
        b1.i_empty       = fe1 || (rp1 >= lim1);
        b1.i_rd_data     = pp1;
        b1.m_axis_tready = tr1;
        b3.i_empty       = fe3 || (rp3 >= lim3);
        b3.i_rd_data     = pp3[2];
        b3.m_axis_tready = tr3;
    endtask

    task automatic step();
        drive();
        @(negedge clk);
        s_rd1 = int'(b1.o_rd_en); s_v1 = int'(b1.m_axis_tvalid);
        s_d1 = int'(b1.m_axis_tdata); s_c1 = int'(b1.o_count);
        s_rd3 = int'(b3.o_rd_en); s_v3 = int'(b3.m_axis_tvalid);
        s_d3 = int'(b3.m_axis_tdata); s_c3 = int'(b3.o_count);
        if (s_v1 != 0 && tr1) begin
            npop1++;
            if (q1.size() == 0) begin
                total++; bad++;
                $display("FAIL beat1: got %02h with no word outstanding", s_d1);
            end else chk("beat1", s_d1, int'(q1.pop_front()));
        end
        if (s_v3 != 0 && tr3) begin
            npop3++;
            if (q3.size() == 0) begin
                total++; bad++;
                $display("FAIL beat3: got %02h with no word outstanding", s_d3);
            end else chk("beat3", s_d3, int'(q3.pop_front()));
        end
        @(posedge clk);
        #1;
        pp3[2] = pp3[1];
        pp3[1] = pp3[0];
        pp3[0] = (s_rd3 != 0) ? w(rp3) : 8'hEE;
        if (s_rd3 != 0) begin q3.push_back(w(rp3)); rp3++; end
        pp1 = (s_rd1 != 0) ? w(rp1) : 8'hEE;
        if (s_rd1 != 0) begin q1.push_back(w(rp1)); rp1++; end
    endtask

    task automatic rst_d1();
        rst1 = 1;
        #2;
        rst1 = 0;
        rp1 = 0; npop1 = 0; pp1 = 8'hEE;
        q1.delete();
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int nrd, guard, first_rd, first_v, gaps, maxc, nx;
        tv[0]  = '{1, 1, 0, 0, 0};
        tv[1]  = '{1, 1, 0, 0, 0};
        tv[2]  = '{1, 1, 1, 8'h01, 1};
        tv[3]  = '{1, 1, 1, 8'h02, 1};
        tv[4]  = '{1, 1, 1, 8'h03, 1};
        tv[5]  = '{1, 1, 1, 8'h04, 1};
        tv[6]  = '{1, 1, 1, 8'h05, 1};
        tv[7]  = '{1, 1, 1, 8'h06, 1};
        tv[8]  = '{1, 0, 1, 8'h07, 1};
        tv[9]  = '{1, 0, 1, 8'h08, 1};
        tv[10] = '{1, 0, 0, -1, 0};
        rst1 = 1; rst3 = 1;
        rp1 = 0; lim1 = 8; rp3 = 0; lim3 = 20; npop1 = 0; npop3 = 0;
        fe1 = 0; fe3 = 0; tr1 = 1; tr3 = 1; pp1 = 8'hEE;
        for (int i = 0; i < 3; i++) pp3[i] = 8'hEE;
        drive();
        #2;
        chk("rst_tvalid", int'(b1.m_axis_tvalid), 0);
        chk("rst_count", int'(b1.o_count), 0);
        chk("rst_tdata", int'(b1.m_axis_tdata), 0);
        chk("rst_rd_en1", int'(b1.o_rd_en), 0);
        chk("rst_rd_en3", int'(b3.o_rd_en), 0);
        @(posedge clk);
        #1;
        rst1 = 0;
        for (int i = 0; i < 11; i++) begin
            tr1 = tv[i].tr;
            step();
            chk($sformatf("stream_rd_c%0d", i), s_rd1, int'(tv[i].rd));
            chk($sformatf("stream_v_c%0d", i), s_v1, int'(tv[i].v));
            chk($sformatf("stream_cnt_c%0d", i), s_c1, tv[i].c);
            if (tv[i].d >= 0) chk($sformatf("stream_d_c%0d", i), s_d1, tv[i].d);
        end
        chk("stream_left", q1.size(), 0);

        rst_d1();
        lim1 = 8; tr1 = 1;
        repeat (3) step();
        tr1 = 0;
        step();
        for (int i = 0; i < 4; i++) begin
            step();
            chk("bp_count", s_c1, 2);
            chk("bp_tdata", s_d1, 8'h02);
            chk("bp_tvalid", s_v1, 1);
            chk("bp_rd_en", s_rd1, 0);
        end
        tr1 = 1;
        repeat (20) step();
        chk("bp_npop", npop1, 8);
        chk("bp_left", q1.size(), 0);

        rst_d1();
        lim1 = 3; nrd = 0;
        for (int i = 0; i < 12; i++) begin
            step();
            nrd += s_rd1;
        end
        chk("empty_reads", nrd, 3);
        chk("empty_beats", npop1, 3);
        chk("empty_tvalid", s_v1, 0);
        lim1 = 6;
        step();
        chk("empty_resume", s_rd1, 1);
        repeat (12) step();
        chk("empty_npop", npop1, 6);
        chk("empty_left", q1.size(), 0);
        lim1 = rp1;

        rst3 = 0;
        first_rd = -1; first_v = -1; gaps = 0; maxc = 0;
        for (int c = 0; c < 30; c++) begin
            step();
            if (s_rd3 != 0 && first_rd < 0) first_rd = c;
            if (s_v3 != 0 && first_v < 0) first_v = c;
            if (first_v >= 0 && c < first_v + 20 && s_v3 == 0) gaps++;
            if (s_c3 > maxc) maxc = s_c3;
        end
        chk("lat_first_rd", first_rd, 0);
        chk("lat_first_beat", first_v - first_rd, 4);
        chk("lat_gaps", gaps, 0);
        chk("lat_max_count", int'(maxc <= 4), 1);
        chk("lat_npop", npop3, 20);

        tr3 = 0;
        lim3 = rp3 + 3;
        guard = 0;
        while (b3.o_count != 3'd2 && guard < 20) begin
            step();
            guard++;
        end
        chk("mf_reach", int'(b3.o_count), 2);
        rst3 = 1;
        #1;
        chk("mf_tvalid", int'(b3.m_axis_tvalid), 0);
        chk("mf_count", int'(b3.o_count), 0);
        chk("mf_tdata", int'(b3.m_axis_tdata), 0);
        q3.delete();
        nx = int'(w(rp3));
        lim3 = rp3 + 4;
        step();
        chk("mf_rd_in_reset", s_rd3, 0);
        rst3 = 0;
        tr3 = 1;
        step();
        chk("mf_resume", s_rd3, 1);
        guard = 0;
        s_v3 = 0;
        while (s_v3 == 0 && guard < 10) begin
            step();
            guard++;
        end
        chk("mf_first_valid", s_v3, 1);
        chk("mf_first_word", s_d3, nx);
        repeat (10) step();
        chk("mf_left", q3.size(), 0);

        lim1 = 1 << 30; lim3 = 1 << 30;
        for (int i = 0; i < 10000; i++) begin
            tr1 = 1'($urandom_range(0, 1));
            tr3 = 1'($urandom_range(0, 1));
            fe1 = ($urandom_range(0, 3) == 0);
            fe3 = ($urandom_range(0, 3) == 0);
            step();
            chk("stress_ovf1", int'(s_c1 <= 2), 1);
            chk("stress_ovf3", int'(s_c3 <= 4), 1);
        end
        fe1 = 1; fe3 = 1; tr1 = 1; tr3 = 1;
        repeat (20) step();
        chk("stress_left1", q1.size(), 0);
        chk("stress_left3", q3.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/fifo_rd_fwft.md
FIFO_RD_FWFT -- requirements
Module: fifo_rd_fwft

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 8, width of read data and stream data.
REQ-002 SHALL have parameter RD_LATENCY, default 1, cycles from o_rd_en high to valid i_rd_data; legal range 1..3.
REQ-003 SHALL use localparam BUF_DEPTH = RD_LATENCY+1, the output buffer entries.
REQ-004 SHALL have port i_clk  input  1  the single clock; all logic is on its rising edge.
REQ-005 SHALL have port i_reset  input  1  asynchronous, active-high reset.
REQ-006 SHALL have port i_empty  input  1  memory-side FIFO empty flag.
REQ-007 SHALL have port o_rd_en  output  1  read request; advances the memory read pointer.
REQ-008 SHALL have port i_rd_data  input  DATA_WIDTH  memory read data, valid RD_LATENCY cycles after o_rd_en.
REQ-009 SHALL have port m_axis_tdata  output  DATA_WIDTH  stream data.
REQ-010 SHALL have port m_axis_tvalid  output  1  stream data valid.
REQ-011 SHALL have port m_axis_tready  input  1  downstream ready.
REQ-012 SHALL have port o_count  output  $clog2(BUF_DEPTH+1)  entries held in the output buffer.

Function
REQ-013 SHALL track in-flight reads with an RD_LATENCY-bit shift register: bit 0 loads o_rd_en each cycle; the bit shifted out marks i_rd_data valid that cycle.
REQ-014 SHALL write i_rd_data into the buffer tail only in a cycle where the in-flight marker is set; otherwise it ignores i_rd_data.
REQ-015 SHALL define pop = m_axis_tvalid AND m_axis_tready; a pop removes the head entry that cycle.
REQ-016 SHALL assert o_rd_en combinationally when !i_empty AND (o_count + in-flight count - pop) < BUF_DEPTH.
REQ-017 SHALL never overflow the buffer; a capture is always accepted because REQ-016 reserves space.
REQ-018 SHALL implement the buffer as a circular array with head/tail indices wrapping from BUF_DEPTH-1 to 0.
REQ-019 SHALL drive m_axis_tvalid = (o_count != 0) and m_axis_tdata = buffer[head], registered state only, no combinational path from i_rd_data.
REQ-020 SHALL hold m_axis_tdata stable while m_axis_tvalid=1 and m_axis_tready=0.
REQ-021 SHALL update o_count by +1 on capture only, -1 on pop only, unchanged on simultaneous capture and pop.
REQ-022 SHALL sustain one beat per cycle with m_axis_tready held high and i_empty held low.
REQ-023 SHALL have first-word latency RD_LATENCY+1 cycles: o_rd_en at cycle N gives m_axis_tvalid=1 at cycle N+RD_LATENCY+1.
REQ-024 SHALL preserve strict FIFO order of words.
REQ-025 SHALL keep buffered words valid when i_empty rises; only new requests stop.

Reset
REQ-026 SHALL, on i_reset high, clear asynchronously: o_count=0, m_axis_tvalid=0, m_axis_tdata=0, head=tail=0, in-flight register=0.
REQ-027 SHALL hold o_rd_en=0 while i_reset is high.
REQ-028 SHALL discard reads in flight when reset asserts mid-operation; returning i_rd_data is ignored.
REQ-029 SHALL resume issuing reads on the first rising edge after i_reset deasserts, if i_empty=0.

Verification
REQ-030 SHALL be tested for streaming: RD_LATENCY=1, 8 words 0x01..0x08, tready=1 -> o_rd_en for 8 consecutive cycles, tvalid from cycle 2, beats 0x01..0x08 back-to-back.
REQ-031 SHALL be tested for backpressure: tready=0 after the first beat -> o_rd_en stops, o_count saturates at 2, tdata holds 0x02; on tready=1 the remaining words arrive in order with no loss.
REQ-032 SHALL be tested for the empty boundary: i_empty rises after 3 reads -> exactly 3 beats, then tvalid=0; o_rd_en stays 0 until i_empty falls.
REQ-033 SHALL be tested for reset mid-flight: reset asserted with 2 buffered and 1 in flight -> tvalid=0 and o_count=0 at once; post-reset stream starts with the next memory word.
REQ-034 SHALL be tested for latency: RD_LATENCY=3 with tready=1 -> first beat 4 cycles after the first o_rd_en, then 1 beat/cycle, o_count <= 4.
REQ-035 SHALL be tested for random stress: random tready and i_empty over 10000 cycles -> scoreboard matches order, with no overflow and no dropped or duplicated words.
